// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks the fetch address, reads program memory
// over a req/ack handshake, and queues {address, opcode} pairs for the
// controller. A redirect flushes the queue and discards any read in flight.
module fetch_unit #(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned       DEPTH     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [7:0]        instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_req_d;
  logic              push, pop, flush;

  logic [ADDR_W-1:0] addr_buf [DEPTH];
  logic [7:0]        data_buf [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  // Head-of-queue view; the controller sees the fetch address when empty
  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? data_buf[rd_ptr] : 8'h00;
  assign pc          = instr_valid ? addr_buf[rd_ptr] : fa_q;

  // Any redirect empties the queue; a redirect also blocks a same-cycle pop
  assign flush = jmp;
  assign pop   = fetch & instr_valid & ~jmp;

  // State and request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fa_q     <= RESET_VEC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_VEC;
    end else begin
      state_q  <= state_d;
      fa_q     <= fa_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
    end
  end

  // Next-state, fetch address, request and push decisions
  always_comb begin
    state_d    = state_q;
    fa_d       = fa_q;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    push       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (jmp) begin
          fa_d = jmp_addr;
        end else if (count < CNT_W'(DEPTH)) begin
          mem_addr_d = fa_q;
          mem_req_d  = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
          if (jmp) begin
            fa_d = jmp_addr;
          end else begin
            push = 1'b1;
            fa_d = fa_q + ADDR_W'(1);
          end
        end else if (jmp) begin
          fa_d    = jmp_addr;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (jmp) fa_d = jmp_addr;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Queue storage; contents are meaningless while count says empty
  always_ff @(posedge clk) begin
    if (push) begin
      addr_buf[wr_ptr] <= mem_addr;
      data_buf[wr_ptr] <= mem_rdata;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 8-bit CPU, sitting directly upstream of the controller. Maintains the fetch address, issues byte reads to program memory over a req/ack handshake, and buffers fetched opcodes in a small FIFO. Presents the head opcode and its address to the controller, pops on the controller's `fetch` strobe, and flushes and redirects on `jmp`.

## Interface
- `ADDR_W`, 16: program address width.
- `RESET_VEC`, 0: fetch address after reset.
- `DEPTH`, 2: prefetch FIFO entries; power of two, ≥2.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `fetch`  in  1  controller consumes the head instruction this cycle.
- `jmp`  in  1  redirect the fetch stream to `jmp_addr`.
- `jmp_addr`  in  ADDR_W  redirect target.
- `instr`  out  8  head opcode; 8'h00 when empty.
- `instr_valid`  out  1  FIFO non-empty.
- `pc`  out  ADDR_W  address of `instr` when valid, else the current fetch address.
- `mem_req`  out  1  read request; registered.
- `mem_addr`  out  ADDR_W  read address; registered; stable while `mem_req` is high.
- `mem_ack`  in  1  read data valid; sampled only while `mem_req` is high.
- `mem_rdata`  in  8  read data, valid with `mem_ack`.

## Operation
- Each FIFO entry holds {address, opcode}. `count` ranges 0..DEPTH. Fetch address `fa` is ADDR_W bits and wraps from all-ones to 0.
- The FSM has three states: IDLE (no read outstanding), WAIT (read outstanding, result kept), DRAIN (read outstanding, result discarded).
- IDLE:
  - `jmp` → flush FIFO, `fa`←`jmp_addr`, stay IDLE.
  - Else if `count`<DEPTH → `mem_addr`←`fa`, `mem_req`←1, go to WAIT.
- WAIT:
  - `mem_ack` and not `jmp` → push {`mem_addr`, `mem_rdata`}, `fa`←`fa`+1, `mem_req`←0, go to IDLE.
  - `mem_ack` and `jmp` → discard data, flush, `fa`←`jmp_addr`, `mem_req`←0, go to IDLE.
  - `jmp` without `mem_ack` → flush, `fa`←`jmp_addr`, go to DRAIN. `mem_req` and `mem_addr` are held.
- DRAIN:
  - `mem_ack` → discard data, `mem_req`←0, go to IDLE.
  - `jmp` → `fa`←`jmp_addr` (latest wins); remain in DRAIN until ack.
- Pop: `fetch` and `instr_valid` and not `jmp` → drop the head.
  - `fetch` while empty is ignored.
  - `jmp` overrides `fetch` in the same cycle.
- Push and pop in the same cycle leave `count` unchanged. Overflow cannot occur, because a request is issued only when `count`<DEPTH and nothing else increments `count`.
- A push into an empty FIFO is not poppable in the same cycle, since `instr_valid` was 0 during that cycle.
- Reset state: IDLE, FIFO empty, `fa`=`mem_addr`=RESET_VEC, `mem_req`=0.
  - Outputs after reset: `instr`=8'h00, `instr_valid`=0, `pc`=RESET_VEC.
  - Reset mid-transaction drops `mem_req` on the next edge. Memory treats a withdrawn request as cancelled, and a late `mem_ack` is ignored because `mem_req` is low.

## Timing
- `instr`, `instr_valid`, and `pc` are combinational from FIFO state; they have no dependence on `fetch` or `jmp` within the same cycle.
- Zero-wait memory (`mem_ack` in the first cycle `mem_req` is high):
  - One read completes per 2 cycles.
  - Edge E0 issues the request; edge E1 completes it and raises `instr_valid`.
- After a `jmp` sampled at edge N in IDLE, `instr_valid` rises at edge N+2 with zero-wait memory.
- After a `jmp` sampled in WAIT, the target read issues one edge after the stale ack.
- `mem_addr` may change only on an edge where `mem_req` goes 0→1.

## Test plan
- Reset, mem at 0x0000..=A0,A1,A2, zero-wait ack, `fetch`=0 → `mem_req` pulses twice then stays low; FIFO holds A0@0x0000, A1@0x0001; `instr`=A0, `pc`=0x0000.
- Hold `fetch`=1 with 3-cycle memory latency → opcodes appear in order A0,A1,A2 with `pc` incrementing by 1; no duplicates, no gaps.
- `jmp`=1, `jmp_addr`=0x1234 while in WAIT with ack delayed 4 cycles → `mem_addr` stays on the old address until ack, stale data is discarded, next `mem_addr`=0x1234, first valid `pc`=0x1234.
- `fetch` and `jmp` (`jmp_addr`=0x0040) asserted in the same cycle with a full FIFO → FIFO empties, no pop is counted, next `instr` comes from 0x0040.
- `fa`=0xFFFF via `jmp` → reads 0xFFFF then 0x0000; `pc` wraps.
- Assert `rst` while `mem_req`=1 and ack pending → `mem_req`=0 next edge, `instr_valid`=0, `pc`=RESET_VEC; a late `mem_ack` produces no push.
